// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding and frame constants.
// Optional parity support is selected with the FIFO_UART_TX_PARITY_EN macro.
package fifo_uart_tx_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period timer: emits a one-cycle tick when the count reaches BIT_CYCLES-1, then wraps to 0.
// A clear input holds the count at zero so every bit starts from a fresh period.
module baud_tick_gen
    import fifo_uart_tx_pkg::*;
#(
    parameter int BIT_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a first-word-fall-through FIFO and sends 8N1 frames.
// Defining FIFO_UART_TX_PARITY_EN inserts an even-parity bit between the data and stop bits.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       tx_busy
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;

    state_t     state;
    state_t     state_next;
    logic [7:0] shift_reg;
    logic [7:0] shift_next;
    logic [2:0] bit_idx;
    logic [2:0] bit_idx_next;
    logic       tx_next;
    logic       tick;
    logic       timer_clear;

    baud_tick_gen #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clear),
        .tick (tick)
    );

    assign tx_busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= IDLE_LEVEL;
            shift_reg <= 8'h00;
            bit_idx   <= 3'd0;
        end else begin
            state     <= state_next;
            tx        <= tx_next;
            shift_reg <= shift_next;
            bit_idx   <= bit_idx_next;
        end
    end

    // tx is registered, so each branch selects the line level for the next state
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx;
        tx_next      = tx;
        fifo_pop     = 1'b0;
        timer_clear  = 1'b0;
        unique case (state)
            IDLE: begin
                timer_clear = 1'b1;
                tx_next     = IDLE_LEVEL;
                if (!fifo_empty && !rst) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_data;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_next   = DATA;
                    bit_idx_next = 3'd0;
                    tx_next      = shift_reg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        bit_idx_next = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_next   = PARITY;
                        tx_next      = ^shift_reg;
`else
                        state_next   = STOP;
                        tx_next      = IDLE_LEVEL;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = shift_reg[bit_idx + 3'd1];
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                    tx_next    = IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                tx_next = IDLE_LEVEL;
                if (tick) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = IDLE_LEVEL;
            end
        endcase
    end

endmodule
